// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the two-register CORDIC datapath: load / iterate / drain one job,
// capture the datapath outputs under valid/ready and cross-check the datapath counter.
module cordic_seq_ctrl #(
  parameter int ITERATIONS   = 8,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic       clka,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       stall,
  input  logic       abort,
  input  logic [3:0] dp_counter,
  input  logic [7:0] dp_out0,
  input  logic [7:0] dp_out1,
  output logic       cordic_mode,
  output logic [1:0] in_mux_ctl,
  output logic       counter_rst,
  output logic       counter_hold,
  output logic       busy,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [7:0] res0,
  output logic [7:0] res1,
  output logic       seq_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] ITER_LAST  = 4'(ITERATIONS - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  localparam logic [1:0] MUX_THETA = 2'b00;
  localparam logic [1:0] MUX_XY    = 2'b10;
  localparam logic [1:0] MUX_FB    = 2'b01;
  localparam logic [1:0] MUX_NONE  = 2'b11;

  state_t     state_q, state_d;
  logic       frozen_q, frozen_d;   // current cycle is a stall cycle
  logic [3:0] iter_q, iter_d;
  logic [1:0] drain_q, drain_d;
  logic       mode_d, err_d, valid_d, capture;
  logic [1:0] mux_d;
  logic       crst_d, hold_d, busy_d;

  // Stall is sampled at the edge and governs the following cycle, so the
  // datapath never advances in a cycle where iter is frozen.
  always_comb begin
    state_d  = state_q;
    frozen_d = 1'b0;
    iter_d   = iter_q;
    drain_d  = drain_q;
    mode_d   = cordic_mode;
    err_d    = seq_err;
    valid_d  = result_valid;
    capture  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      mode_d  = 1'b0;
      err_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            mode_d  = mode;
            err_d   = 1'b0;
            iter_d  = 4'd0;
          end
        end
        S_LOAD: state_d = S_ITER;
        S_ITER: begin
          frozen_d = stall;
          if (!frozen_q) begin
            if (dp_counter != iter_q) err_d = 1'b1;
            if (iter_q == ITER_LAST) begin
              state_d = S_DRAIN;
              drain_d = 2'd0;
            end else begin
              iter_d = iter_q + 4'd1;
            end
          end
        end
        S_DRAIN: begin
          if (frozen_q) begin
            frozen_d = stall;
          end else if (drain_q == DRAIN_LAST) begin
            state_d = S_DONE;
            capture = 1'b1;
            valid_d = 1'b1;
          end else begin
            drain_d  = drain_q + 2'd1;
            frozen_d = stall;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // NOTE: outputs are decoded from the next state and registered, so they
    // line up with the state they describe instead of trailing it by a cycle.
    mux_d  = MUX_NONE;
    crst_d = 1'b0;
    hold_d = 1'b0;
    busy_d = 1'b1;
    case (state_d)
      S_IDLE: begin
        crst_d = 1'b1;
        busy_d = 1'b0;
      end
      S_LOAD: begin
        mux_d  = mode_d ? MUX_XY : MUX_THETA;
        crst_d = 1'b1;
      end
      S_ITER: begin
        mux_d  = frozen_d ? MUX_NONE : MUX_FB;
        hold_d = frozen_d;
      end
      default: hold_d = 1'b1;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frozen_q     <= 1'b0;
      iter_q       <= 4'd0;
      drain_q      <= 2'd0;
      cordic_mode  <= 1'b0;
      in_mux_ctl   <= MUX_NONE;
      counter_rst  <= 1'b1;
      counter_hold <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      res0         <= 8'd0;
      res1         <= 8'd0;
      seq_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frozen_q     <= frozen_d;
      iter_q       <= iter_d;
      drain_q      <= drain_d;
      cordic_mode  <= mode_d;
      in_mux_ctl   <= mux_d;
      counter_rst  <= crst_d;
      counter_hold <= hold_d;
      busy         <= busy_d;
      result_valid <= valid_d;
      seq_err      <= err_d;
      if (capture) begin
        res0 <= dp_out0;
        res1 <= dp_out1;
      end
    end
  end

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Sequencer for the two-register CORDIC datapath. It accepts one rotation or vectoring job through a start/busy handshake and drives the datapath's `in_mux_ctl`, `counter_rst`, `counter_hold` and `cordic_mode` through load, iterate and drain. It captures the datapath outputs into a result buffer held under a valid/ready handshake, and checks the datapath's iteration counter against its own count. It sits between the system bus front-end and the CORDIC datapath, one controller per datapath.

## Interface
- `ITERATIONS`, default 8: micro-rotations per job; legal range 1..15.
- `DRAIN_CYCLES`, default 1: idle cycles after the last iteration before capture; legal range 1..3.

Ports:
- `clka` in 1: sole clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `mode` in 1: 0 = rotation, 1 = vectoring; latched with `start`.
- `stall` in 1: freezes iteration while high (ITER and DRAIN only).
- `abort` in 1: cancels any job and returns to IDLE.
- `dp_counter` in 4: datapath iteration counter.
- `dp_out0` in 8: datapath port 0 (x or theta).
- `dp_out1` in 8: datapath port 1 (y).
- `cordic_mode` out 1: latched mode, driven to the datapath.
- `in_mux_ctl` out 2: datapath load select; 00 = load theta, 10 = load x/y, 01 = feedback, 11 = no load.
- `counter_rst` out 1: datapath counter clear.
- `counter_hold` out 1: datapath counter hold.
- `busy` out 1: high from the cycle after an accepted `start` until return to IDLE.
- `result_valid` out 1: result buffer holds a completed job.
- `result_ready` in 1: consumer accepts the result.
- `res0` out 8: captured `dp_out0`.
- `res1` out 8: captured `dp_out1`.
- `seq_err` out 1: sticky counter-mismatch flag for the current job.

## Operation
- All outputs are registered. Reset values: `in_mux_ctl`=11, `counter_rst`=1, `counter_hold`=0, `cordic_mode`=0, `busy`=0, `result_valid`=0, `res0`/`res1`=0, `seq_err`=0. State after reset is IDLE.
- IDLE: `in_mux_ctl`=11, `counter_rst`=1. On `start`, latch `mode` into `cordic_mode`, clear `seq_err`, set `iter`=0, and go to LOAD.
- LOAD (exactly 1 cycle, ignores `stall`): `in_mux_ctl` = 00 if mode=0, else 10. Keep `counter_rst`=1, then go to ITER.
- ITER: `in_mux_ctl`=01, `counter_rst`=0, `counter_hold`=0, `iter` increments each cycle.
  - Each ITER cycle, compare `dp_counter` with `iter`; on mismatch set `seq_err` (sticky; the job still completes).
  - When `iter` reaches ITERATIONS-1, go to DRAIN with a drain count of 0.
- DRAIN: `in_mux_ctl`=11, `counter_hold`=1. After DRAIN_CYCLES cycles, load `res0`/`res1` from `dp_out0`/`dp_out1`, set `result_valid`, and go to DONE.
- DONE: `in_mux_ctl`=11, `counter_hold`=1, `busy`=1. When `result_valid` and `result_ready` are both high, clear `result_valid` and go to IDLE (`counter_rst`=1 next cycle).
- `stall` in ITER or DRAIN: drive `in_mux_ctl`=11 and `counter_hold`=1, freeze `iter` and the drain count, and skip the mismatch check. Resume in the same state when `stall` falls.
- `iter` is 4 bits wide. It never wraps because ITERATIONS ≤ 15.
- `res0`/`res1` are stable while `result_valid` is high; they change only at capture.

## Timing
- A `start` accepted at edge N gives: LOAD at N+1, ITER at N+2..N+1+ITERATIONS, DRAIN for DRAIN_CYCLES cycles, then `result_valid` high at edge N+2+ITERATIONS+DRAIN_CYCLES.
- Default latency from `start` to `result_valid` is 11 cycles.
- `start` outside IDLE is ignored and has no queue. `start` on the same cycle as the IDLE return from a DONE handshake is also ignored; it is accepted from the following cycle.
- `abort` has priority over every transition except `rst`. The next cycle is IDLE with reset output values, except that `res0`/`res1` keep their contents and `seq_err` is cleared.
- `rst` mid-job has the same effect as reset from power-up; `res0`/`res1` clear to 0.
- `result_ready` outside DONE is ignored.
- `abort` and `result_ready` asserted together in DONE: `abort` wins, and the result is dropped with `result_valid`=0.

## Test plan
- Rotation, mode=0, `start` for 1 cycle, `dp_counter` mirroring `iter`, `dp_out0`=0x5A and `dp_out1`=0x33 at capture -> `in_mux_ctl` sequence 11,00,01×8,11; `result_valid` at cycle 11; `res0`=0x5A, `res1`=0x33; `seq_err`=0.
- Vectoring, mode=1 -> LOAD drives `in_mux_ctl`=10 and `cordic_mode`=1 throughout. Hold `result_ready` low for 5 cycles -> `result_valid` and `res0`/`res1` held constant. Raise `result_ready` -> IDLE next cycle, `busy`=0.
- `stall` high for 3 cycles at iter=4 -> `in_mux_ctl`=11 and `counter_hold`=1 for 3 cycles, then resume at iter=4; latency becomes 14; `seq_err`=0.
- Force `dp_counter`=2 when iter=3 -> `seq_err` rises and stays high through DONE; cleared on the next accepted `start`.
- `abort` at iter=6; separately, `abort` together with `result_ready` in DONE -> next cycle is IDLE, `result_valid`=0, `counter_rst`=1, `res0`/`res1` unchanged.
- `rst` asserted during DRAIN; `start` pulsed while `busy` -> all outputs at reset values after `rst`; the mid-job `start` produces no second job.
